// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU between NREQ requesters.
// One op in flight; valid/ready toward requesters, start/done toward ALU.
module alu_arbiter #(
   parameter int NREQ    = 4,
   parameter int WIDTH   = 32,
   parameter int OPW     = 4,
   parameter int TIMEOUT = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*OPW-1:0]   req_op,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   output logic [NREQ-1:0]       rsp_valid,
   input  logic [NREQ-1:0]       rsp_ready,
   output logic [WIDTH-1:0]      rsp_data,
   output logic                  rsp_err,
   output logic                  alu_start,
   output logic [OPW-1:0]        alu_op,
   output logic [WIDTH-1:0]      alu_a,
   output logic [WIDTH-1:0]      alu_b,
   input  logic                  alu_done,
   input  logic [WIDTH-1:0]      alu_res,
   output logic                  busy
);

   localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int TW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [LW-1:0]    r_last;
   logic [LW-1:0]    r_grant;
   logic [OPW-1:0]   r_op;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_data;
   logic             r_err;
   logic [TW-1:0]    r_timer;
   logic             w_found;
   logic [LW-1:0]    w_gnt;
   logic             w_expire;

   assign w_expire  = (r_timer == TW'(TIMEOUT - 1));
   assign alu_op    = r_op;
   assign alu_a     = r_a;
   assign alu_b     = r_b;
   assign rsp_data  = r_data;
   assign rsp_err   = r_err;
   assign busy      = (r_state != S_IDLE);

   // Round-robin pick: first valid index after last_grant, wrapping.
   always_comb begin
      int k;
      k       = 0;
      w_found = 1'b0;
      w_gnt   = '0;
      for (int i = 1; i <= NREQ; i++) begin
         k = (int'(r_last) + i) % NREQ;
         if (!w_found && req_valid[k]) begin
            w_found = 1'b1;
            w_gnt   = LW'(k);
         end
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Next state and handshake outputs; req_ready forced low while in reset.
   always_comb begin
      w_next    = r_state;
      req_ready = '0;
      rsp_valid = '0;
      alu_start = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_found) begin
               req_ready[w_gnt] = rst_n;
               w_next           = S_ISSUE;
            end
         end
         S_ISSUE: begin
            alu_start = 1'b1;
            w_next    = S_WAIT;
         end
         S_WAIT: begin
            if (alu_done || w_expire) w_next = S_RESP;
         end
         S_RESP: begin
            rsp_valid[r_grant] = 1'b1;
            if (rsp_ready[r_grant]) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Operand latch, watchdog timer, result capture and grant history.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last  <= LW'(NREQ - 1);
         r_grant <= '0;
         r_op    <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_data  <= '0;
         r_err   <= 1'b0;
         r_timer <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_grant <= w_gnt;
                  r_op    <= req_op[int'(w_gnt)*OPW +: OPW];
                  r_a     <= req_a[int'(w_gnt)*WIDTH +: WIDTH];
                  r_b     <= req_b[int'(w_gnt)*WIDTH +: WIDTH];
               end
            end
            S_ISSUE: r_timer <= '0;
            S_WAIT: begin
               if (alu_done) begin
                  r_data <= alu_res;
                  r_err  <= 1'b0;
               end else if (w_expire) begin
                  r_data <= '0;
                  r_err  <= 1'b1;
               end else begin
                  r_timer <= r_timer + TW'(1);
               end
            end
            S_RESP: begin
               if (rsp_ready[r_grant]) r_last <= r_grant;
            end
            default: ;
         endcase
      end
   end

endmodule
